// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR receive path: controller states, the
// accepted duration window of every frame phase (in 10 us timing ticks),
// and a small window-compare helper.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_MARK
  } state_e;

  localparam int unsigned NEC_BITS = 32;

  // Inclusive duration windows, in timing ticks.
  localparam int unsigned LEAD_MARK_MIN  = 800;
  localparam int unsigned LEAD_MARK_MAX  = 1000;
  localparam int unsigned LEAD_SPACE_MIN = 400;
  localparam int unsigned LEAD_SPACE_MAX = 500;
  localparam int unsigned RPT_SPACE_MIN  = 200;
  localparam int unsigned RPT_SPACE_MAX  = 250;
  localparam int unsigned BIT_MARK_MIN   = 40;   // also used for the stop mark
  localparam int unsigned BIT_MARK_MAX   = 70;
  localparam int unsigned SPACE0_MIN     = 40;
  localparam int unsigned SPACE0_MAX     = 70;
  localparam int unsigned SPACE1_MIN     = 140;
  localparam int unsigned SPACE1_MAX     = 190;

  function automatic logic in_win(input logic [31:0] v,
                                  input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer plus edge detector for the raw IR receiver pin.
// The pin idles high, so every flop resets to 1: a line already low when
// reset releases is therefore seen as a fall.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   d_i        : asynchronous raw input
//   level_o    : synchronized level
//   fall_o     : one-cycle pulse on a 1->0 transition of the synced level
//   rise_o     : one-cycle pulse on a 0->1 transition of the synced level
module ir_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;
  assign rise_o  = ~prev_q & sync_q;

endmodule

// File: rtl/ir_nec_rx_ctrl.sv
// NEC IR frame receiver controller. Times each mark and space of the
// conditioned receiver line, walks leader / 32 data bits / stop mark, and
// publishes the assembled word. Also recognises repeat codes and aborts on
// any out-of-window phase or a phase that runs TIMEOUT ticks.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   ir_rx        : raw active-low receiver output (low = mark), async
//   frame_data   : last accepted frame, first received bit in bit 0
//   frame_valid  : one-cycle pulse when frame_data updates
//   repeat_valid : one-cycle pulse on a valid repeat code
//   frame_err    : one-cycle pulse on any abort
//   busy         : high whenever the controller is not IDLE
module ir_nec_rx_ctrl
  import ir_nec_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned TIMEOUT   = 1100,
  parameter bit          CHECK_INV = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_rx,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic rx_level, fall, rise;
  logic edge_det, mark_start, mark_end;
  logic tick, timeout, inv_ok, abort;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         cnt_ext;
  state_e              state_q, state_d;
  logic [NEC_BITS-1:0] shift_q, shift_d;
  logic [NEC_BITS-1:0] frame_data_q, frame_data_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic                have_frame_q, have_frame_d;
  logic                valid_q, valid_d, rpt_q, rpt_d, err_q, err_d;

  ir_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_i     (ir_rx),
    .level_o (rx_level),
    .fall_o  (fall),
    .rise_o  (rise)
  );

  // Direction of an edge comes from the level it settled to.
  assign edge_det   = fall | rise;
  assign mark_start = edge_det & ~rx_level;
  assign mark_end   = edge_det & rx_level;

  assign tick    = (pre_q == PRE_W'(TICK_DIV - 1));
  assign cnt_ext = 32'(cnt_q);
  assign timeout = (cnt_ext >= TIMEOUT);
  assign inv_ok  = !CHECK_INV || (shift_q[31:24] == ~shift_q[23:16]);

  // Phase timer: an edge restarts both prescaler and counter, and wins over
  // a coincident tick so the next phase starts from zero.
  always_comb begin
    pre_d = pre_q + 1'b1;
    cnt_d = cnt_q;
    if (edge_det) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    frame_data_d = frame_data_q;
    have_frame_d = have_frame_q;
    valid_d      = 1'b0;
    rpt_d        = 1'b0;
    err_d        = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: if (mark_start) state_d = LEAD_MARK;
      LEAD_MARK: if (mark_end) begin
        if (in_win(cnt_ext, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
        else abort = 1'b1;
      end
      LEAD_SPACE: if (mark_start) begin
        if (in_win(cnt_ext, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
          state_d   = BIT_MARK;
          bit_idx_d = '0;
        end else if (in_win(cnt_ext, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
          state_d = RPT_MARK;
        end else begin
          abort = 1'b1;
        end
      end
      BIT_MARK: if (mark_end) begin
        if (in_win(cnt_ext, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
        else abort = 1'b1;
      end
      BIT_SPACE: if (mark_start) begin
        if (in_win(cnt_ext, SPACE0_MIN, SPACE0_MAX) ||
            in_win(cnt_ext, SPACE1_MIN, SPACE1_MAX)) begin
          shift_d[bit_idx_q] = in_win(cnt_ext, SPACE1_MIN, SPACE1_MAX);
          bit_idx_d          = bit_idx_q + 5'd1;
          state_d = (bit_idx_q == 5'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
        end else begin
          abort = 1'b1;
        end
      end
      STOP_MARK: if (mark_end) begin
        if (in_win(cnt_ext, BIT_MARK_MIN, BIT_MARK_MAX) && inv_ok) begin
          frame_data_d = shift_q;
          have_frame_d = 1'b1;
          valid_d      = 1'b1;
          state_d      = IDLE;
        end else begin
          abort = 1'b1;
        end
      end
      RPT_MARK: if (mark_end) begin
        if (in_win(cnt_ext, BIT_MARK_MIN, BIT_MARK_MAX) && have_frame_q) begin
          rpt_d   = 1'b1;
          state_d = IDLE;
        end else begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A phase that never ends is a dead frame; an edge in the same cycle
    // has already been judged above.
    if (state_q != IDLE && !edge_det && timeout) abort = 1'b1;

    if (abort) begin
      err_d   = 1'b1;
      state_d = IDLE;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      frame_data_q <= '0;
      have_frame_q <= 1'b0;
      valid_q      <= 1'b0;
      rpt_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      frame_data_q <= frame_data_d;
      have_frame_q <= have_frame_d;
      valid_q      <= valid_d;
      rpt_q        <= rpt_d;
      err_q        <= err_d;
    end
  end

  assign frame_data   = frame_data_q;
  assign frame_valid  = valid_q;
  assign repeat_valid = rpt_q;
  assign frame_err    = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ir_nec_rx_ctrl.sv
// Bench for ir_nec_rx_ctrl. Two instances run side by side on separate
// receiver lines: unit 0 without and unit 1 with the command integrity
// check. Each stimulus pushes its expected pulse into that unit's queue; a
// monitor thread pops and compares whenever a unit raises a pulse.
module tb_ir_nec_rx_ctrl;

  localparam int TICK_DIV = 4;

  typedef enum logic [2:0] {
    EV_FRAME = 3'b001,
    EV_RPT   = 3'b010,
    EV_ERR   = 3'b100
  } ev_e;

  typedef struct packed {
    ev_e         kind;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    int lm;
    int ls;
    int mk;
    int s0;
    int s1;
  } tim_t;

  localparam tim_t NOM  = '{900, 450, 56, 56, 169};
  localparam tim_t FAST = '{820, 420, 45, 45, 150};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rx;
  logic [31:0] fd [2];
  logic [1:0]  fv, rv, fe, bz;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ir_nec_rx_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(11), .TIMEOUT(1100), .CHECK_INV(1'b0)) dut_a (
    .clk(clk), .reset(reset), .ir_rx(rx[0]), .frame_data(fd[0]),
    .frame_valid(fv[0]), .repeat_valid(rv[0]), .frame_err(fe[0]), .busy(bz[0])
  );

  ir_nec_rx_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(11), .TIMEOUT(1100), .CHECK_INV(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ir_rx(rx[1]), .frame_data(fd[1]),
    .frame_valid(fv[1]), .repeat_valid(rv[1]), .frame_err(fe[1]), .busy(bz[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input int w, input ev_e k, input logic [31:0] d);
    if (w == 0) q0.push_back('{k, d});
    else        q1.push_back('{k, d});
  endtask

  task automatic monitor();
    logic [2:0] ev;
    exp_t       e;
    logic       have;
    forever begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        ev = {fe[w], rv[w], fv[w]};
        if (ev != 3'b000) begin
          have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!have) begin
            check(w == 0 ? "a_unexpected_pulse" : "b_unexpected_pulse", 32'(ev), 32'd0);
          end else begin
            if (w == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check(w == 0 ? "a_event_kind" : "b_event_kind", 32'(ev), 32'(e.kind));
            check(w == 0 ? "a_event_data" : "b_event_data", fd[w], e.data);
          end
        end
      end
    end
  endtask

  task automatic drive(input int w, input logic lvl, input int ticks);
    rx[w] = lvl;
    repeat (ticks * TICK_DIV) @(negedge clk);
  endtask

  task automatic send_lead_bits(input int w, input logic [31:0] d, input int nbits, input tim_t t);
    drive(w, 1'b0, t.lm);
    drive(w, 1'b1, t.ls);
    for (int i = 0; i < nbits; i++) begin
      drive(w, 1'b0, t.mk);
      drive(w, 1'b1, d[i] ? t.s1 : t.s0);
    end
  endtask

  task automatic send_frame(input int w, input logic [31:0] d, input tim_t t);
    send_lead_bits(w, d, 32, t);
    drive(w, 1'b0, t.mk);
    drive(w, 1'b1, 10);
  endtask

  task automatic send_repeat(input int w);
    drive(w, 1'b0, 900);
    drive(w, 1'b1, 225);
    drive(w, 1'b0, 56);
    drive(w, 1'b1, 10);
  endtask

  // Waits from the current negedge until frame_err of unit w, counting
  // negedges; also reports busy one sample before the pulse.
  task automatic wait_err(input int w, input int budget, output int n, output logic busy_before);
    n = 0;
    busy_before = 1'b0;
    while (fe[w] !== 1'b1 && n < budget) begin
      busy_before = bz[w];
      @(negedge clk);
      n++;
    end
  endtask

  // Bit 17 space of 100 ticks lands between the 0 and 1 windows.
  task automatic send_bad17(input int w);
    int   n;
    logic bb;
    send_lead_bits(w, 32'h0, 17, FAST);
    drive(w, 1'b0, FAST.mk);
    drive(w, 1'b1, 100);
    rx[w] = 1'b0;
    wait_err(w, 64, n, bb);
    check("bad_space_err_seen", 32'(fe[w]), 32'd1);
    check("bad_space_busy_low", 32'(bz[w]), 32'd0);
    drive(w, 1'b0, FAST.mk);
    drive(w, 1'b1, 10);
  endtask

  // Line goes low and stays there: leader mark never ends.
  task automatic send_stuck_low(input int w);
    int   n;
    logic bb;
    rx[w] = 1'b0;
    wait_err(w, 6000, n, bb);
    check("timeout_err_seen", 32'(fe[w]), 32'd1);
    check_range("timeout_cycles_from_pin", n, 4401, 4406);
    check("timeout_busy_before", 32'(bb), 32'd1);
    check("timeout_busy_after", 32'(bz[w]), 32'd0);
    drive(w, 1'b1, 10);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int w = 0; w < 2; w++) begin
      check({tag, "_frame_data"}, fd[w], 32'd0);
      check({tag, "_frame_valid"}, 32'(fv[w]), 32'd0);
      check({tag, "_repeat_valid"}, 32'(rv[w]), 32'd0);
      check({tag, "_frame_err"}, 32'(fe[w]), 32'd0);
      check({tag, "_busy"}, 32'(bz[w]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 2'b11;
    fork
      monitor();
    join_none

    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Unit 0: repeat with no stored frame, bad bit 17, nominal frame, repeat.
    // Unit 1: integrity-clean frame, then one whose byte3 is not ~byte2.
    fork
      begin
        push(0, EV_ERR, 32'h0);
        send_repeat(0);
        push(0, EV_ERR, 32'h0);
        send_bad17(0);
        push(0, EV_FRAME, 32'hB857E02F);
        send_frame(0, 32'hB857E02F, NOM);
        push(0, EV_RPT, 32'hB857E02F);
        send_repeat(0);
      end
      begin
        push(1, EV_FRAME, 32'hF708FF00);
        send_frame(1, 32'hF708FF00, FAST);
        push(1, EV_ERR, 32'hF708FF00);
        send_frame(1, 32'hF608FF00, FAST);
      end
    join
    check("a_data_after_repeat", fd[0], 32'hB857E02F);
    check("b_data_kept_on_inv_fail", fd[1], 32'hF708FF00);

    // Reset in the middle of bit 20 on unit 0.
    send_lead_bits(0, 32'h0, 20, FAST);
    rx[0] = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    rx[0] = 1'b1;
    @(negedge clk);
    check_idle_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    fork
      begin
        push(0, EV_FRAME, 32'h0000A5C3);
        send_frame(0, 32'h0000A5C3, FAST);
      end
      begin
        push(1, EV_ERR, 32'h0);
        send_stuck_low(1);
      end
    join

    repeat (50) @(negedge clk);
    check("a_expected_all_seen", 32'(q0.size()), 32'd0);
    check("b_expected_all_seen", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_nec_rx_ctrl.md
Name: ir_nec_rx_ctrl

Overview:
- Front-end controller for the IR keypad path. Samples the raw demodulated IR receiver pin and times each mark and space of an NEC frame.
- Sequences leader, 32 data bits and stop mark, then publishes the assembled 32-bit word with a one-cycle strobe.
- frame_data drives the decoder's 32-bit code input; frame_valid drives its latch input.
- Also detects NEC repeat codes and rejects malformed frames.

Parameters:
- TICK_DIV, 500: clk cycles per timing tick. 500 gives 10 us at 50 MHz; the bench uses 4.
- CNT_W, 11: width of the tick counter, which saturates at all-ones.
- TIMEOUT, 1100: ticks in any single phase before abort.
- CHECK_INV, 0: when 1, require byte3 == ~byte2 (command integrity check).

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- ir_rx, input, 1: raw receiver output; active-low (low = mark); asynchronous to clk.
- frame_data, output, 32: last accepted frame; first received bit in bit 0.
- frame_valid, output, 1: one-cycle pulse when frame_data updates.
- repeat_valid, output, 1: one-cycle pulse on a valid repeat code.
- frame_err, output, 1: one-cycle pulse on any abort.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, frame_data = 0, state IDLE, synchronizer flops = 1, tick prescaler = 0, tick counter = 0, bit index = 0, have_frame = 0.
- Input conditioning: ir_rx passes through a 2-flop synchronizer, then edge detection. fall = mark start, rise = mark end. Edge latency is 3 clk from the pin.
- Timing base:
  - The prescaler emits a tick every TICK_DIV clk.
  - The tick counter clears on every detected edge; the prescaler also clears on every edge.
  - The counter increments per tick and saturates.
  - Each phase is measured in ticks at the edge that ends it.
- Windows, inclusive, in 10 us ticks:
  - LEAD_MARK: 800..1000.
  - LEAD_SPACE: 400..500 for data; 200..250 for repeat.
  - BIT_MARK / STOP_MARK: 40..70.
  - Space 0: 40..70. Space 1: 140..190.
- States and transitions:
  - IDLE: on fall -> LEAD_MARK.
  - LEAD_MARK: on rise, in window -> LEAD_SPACE; otherwise err.
  - LEAD_SPACE: on fall, data window -> BIT_MARK with bit index = 0; repeat window -> RPT_MARK; otherwise err.
  - BIT_MARK: on rise, in window -> BIT_SPACE; otherwise err.
  - BIT_SPACE: on fall, classify 0/1 and write the bit into shift[bit_idx], then increment the index.
    - If the index was 31 -> STOP_MARK; else -> BIT_MARK.
    - Out-of-window -> err.
  - STOP_MARK: on rise, in window (and CHECK_INV passes when enabled):
    - frame_data <= shift, frame_valid = 1 for one cycle, have_frame <= 1, then -> IDLE.
    - Failed integrity check -> err, and frame_data is unchanged.
  - RPT_MARK: on rise, in window and have_frame -> repeat_valid = 1 for one cycle, then -> IDLE. Otherwise err.
- Timeout: in any non-IDLE state, counter reaching TIMEOUT without an edge -> err.
- err: frame_err = 1 for one cycle, return to IDLE, and discard the shift register. frame_data and have_frame are untouched.
- Output timing: frame_valid, repeat_valid and frame_err are registered and asserted the cycle after the deciding edge; they are mutually exclusive.
- Line held low from reset: the synchronizer resets to 1, so the first sample yields fall -> LEAD_MARK, which times out -> frame_err. The block then stays in IDLE until the next fall.
- A fall and the prescaler wrap in the same cycle: the edge wins (counter cleared).
- Reset mid-frame: immediate return to IDLE with no pulse outputs, and frame_data cleared.

Decomposition:
- Package ir_nec_pkg:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK);
  - window constants (min/max for each phase, as listed above);
  - NEC_BITS = 32.
- Sub-module ir_sync_edge: 2-flop synchronizer with reset value 1; outputs the synced level, fall and rise.

Test Plan (TICK_DIV = 4, durations expressed in ticks):
1. Full frame 0xB857E02F with nominal timings (900/450, marks 56, spaces 56/169, stop 56) -> one frame_valid pulse; frame_data = 0xB857E02F; frame_err never asserted.
2. After test 1, repeat code (900/225/56) -> repeat_valid pulse with frame_data still 0xB857E02F. Repeat code immediately after reset -> frame_err and no repeat_valid.
3. CHECK_INV = 1: frame 0xF708FF00 -> frame_valid. Frame 0xF608FF00 -> frame_err, and frame_data keeps 0xF708FF00.
4. Bit-17 space of 100 ticks (between windows) -> frame_err at that edge, then busy = 0; a following good frame decodes correctly.
5. Line stuck low after the leader mark begins -> frame_err exactly when the counter reaches 1100 ticks; busy drops the next cycle.
6. reset asserted during bit 20 -> all outputs 0 the next cycle, frame_data = 0; a subsequent full frame decodes normally.
